mem_port_arbiter: RTL and testbench

Sequencer for the single data-memory port shared by the store reservation station and the load buffer. Each cycle in IDLE it picks one pending request, drives the memory port, and returns a handshake acknowledge. For loads it waits out the fixed memory latency and broadcasts the result on the common data bus (CDB) under its reservation tag. It sits between the load/store reservation stations and data memory, and is the only CDB source for load results.

---
 rtl/mem_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one data-memory port between the store RS and the load buffer,
// and broadcasts load results on the CDB after the fixed memory latency.
`default_nettype none

module mem_port_arbiter #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int TAG_W   = 4,
  parameter int MEM_LAT = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              st_req,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              st_ack,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [TAG_W-1:0]  ld_tag,
  output logic              ld_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cdb_valid,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_data,
  input  logic              cdb_stall,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    BCAST = 2'd3
  } state_t;

  localparam int CNT_W = 5;
  // The count covers the mem_en cycle as well, so read data is captured
  // MEM_LAT cycles after the strobe.
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT + 1);

  state_t            state, state_nx;
  logic              rr_ld, rr_ld_nx;  // 1: load wins the next address-distinct tie
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [TAG_W-1:0]  tag, tag_nx;
  logic              st_ack_nx, ld_ack_nx, mem_en_nx, mem_we_nx, cdb_valid_nx, busy_nx;
  logic [ADDR_W-1:0] mem_addr_nx;
  logic [DATA_W-1:0] mem_wdata_nx, cdb_data_nx;
  logic [TAG_W-1:0]  cdb_tag_nx;
  logic              grant_st, grant_ld;

  always_comb begin
    grant_st = 1'b0;
    grant_ld = 1'b0;
    if (st_req && ld_req) begin
      // Same address: the store goes first so the load sees the new value.
      if ((st_addr == ld_addr) || !rr_ld) grant_st = 1'b1;
      else                                grant_ld = 1'b1;
    end else if (st_req) begin
      grant_st = 1'b1;
    end else if (ld_req) begin
      grant_ld = 1'b1;
    end
  end

  always_comb begin
    state_nx     = state;
    rr_ld_nx     = rr_ld;
    cnt_nx       = cnt;
    tag_nx       = tag;
    st_ack_nx    = 1'b0;
    ld_ack_nx    = 1'b0;
    mem_en_nx    = 1'b0;
    mem_we_nx    = 1'b0;
    mem_addr_nx  = mem_addr;
    mem_wdata_nx = mem_wdata;
    cdb_valid_nx = 1'b0;
    cdb_tag_nx   = cdb_tag;
    cdb_data_nx  = cdb_data;

    case (state)
      IDLE: begin
        if (grant_st) begin
          state_nx     = WRITE;
          rr_ld_nx     = 1'b1;
          mem_addr_nx  = st_addr;
          mem_wdata_nx = st_data;
          mem_en_nx    = 1'b1;
          mem_we_nx    = 1'b1;
          st_ack_nx    = 1'b1;
        end else if (grant_ld) begin
          state_nx    = READ;
          rr_ld_nx    = 1'b0;
          mem_addr_nx = ld_addr;
          tag_nx      = ld_tag;
          cnt_nx      = LAT_LOAD;
          mem_en_nx   = 1'b1;
          ld_ack_nx   = 1'b1;
        end
      end
      WRITE: state_nx = IDLE;
      READ: begin
        cnt_nx = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_nx     = BCAST;
          cdb_data_nx  = mem_rdata;
          cdb_tag_nx   = tag;
          cdb_valid_nx = 1'b1;
        end
      end
      BCAST: begin
        cdb_valid_nx = 1'b1;
        if (!cdb_stall) begin
          state_nx     = IDLE;
          cdb_valid_nx = 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase

    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rr_ld     <= 1'b0;
      cnt       <= '0;
      tag       <= '0;
      st_ack    <= 1'b0;
      ld_ack    <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      rr_ld     <= rr_ld_nx;
      cnt       <= cnt_nx;
      tag       <= tag_nx;
      st_ack    <= st_ack_nx;
      ld_ack    <= ld_ack_nx;
      mem_en    <= mem_en_nx;
      mem_we    <= mem_we_nx;
      mem_addr  <= mem_addr_nx;
      mem_wdata <= mem_wdata_nx;
      cdb_valid <= cdb_valid_nx;
      cdb_tag   <= cdb_tag_nx;
      cdb_data  <= cdb_data_nx;
      busy      <= busy_nx;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a MEM_LAT-deep read-pipeline memory model.
`default_nettype none

module tb_mem_port_arbiter;
  localparam int MEM_LAT = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        st_req = 1'b0, ld_req = 1'b0, cdb_stall = 1'b0;
  logic [15:0] st_addr = '0, st_data = '0, ld_addr = '0;
  logic [3:0]  ld_tag = '0;
  logic        st_ack, ld_ack, mem_en, mem_we, cdb_valid, busy;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, cdb_data;
  logic [3:0]  cdb_tag;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.DATA_W(16), .ADDR_W(16), .TAG_W(4), .MEM_LAT(MEM_LAT)) dut (
    .clock(clock), .reset(reset),
    .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_ack(st_ack),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_tag(ld_tag), .ld_ack(ld_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_stall(cdb_stall),
    .busy(busy)
  );

  always #5 clock = ~clock;

  // Memory: default contents A0xx, 0x20 holds 0x1234; read data is X except MEM_LAT cycles after a read strobe.
  logic [15:0] mem   [0:255];
  logic [15:0] rpipe [0:MEM_LAT-1];
  always @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'hA000 | 16'(i);
      mem[8'h20] <= 16'h1234;
    end else if (mem_en && mem_we) begin
      mem[mem_addr[7:0]] <= mem_wdata;
    end
    rpipe[0] <= (mem_en && !mem_we) ? mem[mem_addr[7:0]] : 16'hxxxx;
    for (int i = 1; i < MEM_LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign mem_rdata = rpipe[MEM_LAT-1];

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if ({st_ack, ld_ack, mem_en, mem_we, cdb_valid, busy, mem_addr, mem_wdata, cdb_tag, cdb_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got ack=%b%b en=%b we=%b v=%b busy=%b addr=%h wd=%h tag=%h data=%h exp all zero",
               st_ack, ld_ack, mem_en, mem_we, cdb_valid, busy, mem_addr, mem_wdata, cdb_tag, cdb_data);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_store();
    st_req = 1'b1; st_addr = 16'h0010; st_data = 16'hBEEF;
    tick();
    checks++;
    if ({mem_en, mem_we, st_ack, ld_ack, busy, mem_addr, mem_wdata} !== {5'b11101, 16'h0010, 16'hBEEF}) begin
      errors++;
      $display("FAIL store_write got en=%b we=%b sa=%b la=%b busy=%b addr=%h wd=%h exp 1 1 1 0 1 0010 beef",
               mem_en, mem_we, st_ack, ld_ack, busy, mem_addr, mem_wdata);
    end
    st_req = 1'b0;
    tick();
    checks++;
    if ({mem_en, st_ack, busy} !== 3'b000) begin
      errors++;
      $display("FAIL store_done got en=%b ack=%b busy=%b exp 000", mem_en, st_ack, busy);
    end
  endtask

  task automatic test_load();
    ld_req = 1'b1; ld_addr = 16'h0020; ld_tag = 4'b0100;
    tick();
    checks++;
    if ({ld_ack, st_ack, mem_en, mem_we, busy, mem_addr} !== {5'b10101, 16'h0020}) begin
      errors++;
      $display("FAIL load_accept got la=%b sa=%b en=%b we=%b busy=%b addr=%h exp 1 0 1 0 1 0020",
               ld_ack, st_ack, mem_en, mem_we, busy, mem_addr);
    end
    ld_req = 1'b0;
    tick();
    tick();
    checks++;
    if ({ld_ack, mem_en, cdb_valid, busy} !== 4'b0001) begin
      errors++;
      $display("FAIL load_wait got la=%b en=%b v=%b busy=%b exp 0 0 0 1", ld_ack, mem_en, cdb_valid, busy);
    end
    tick();
    checks++;
    if ({cdb_valid, cdb_tag, cdb_data} !== {1'b1, 4'b0100, 16'h1234}) begin
      errors++;
      $display("FAIL load_bcast got v=%b tag=%b data=%h exp 1 0100 1234", cdb_valid, cdb_tag, cdb_data);
    end
    tick();
    checks++;
    if ({cdb_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL load_end got v=%b busy=%b exp 00", cdb_valid, busy);
    end
  endtask

  // Previous grant was a load, so the alternation starts with the store.
  task automatic test_round_robin();
    logic found;
    st_req = 1'b1; st_addr = 16'h0040; st_data = 16'h5500;
    ld_req = 1'b1; ld_addr = 16'h0050; ld_tag = 4'd2;
    for (int k = 0; k < 4; k++) begin
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
        tick();
        if (st_ack || ld_ack) found = 1'b1;
      end
      checks++;
      if (!found) begin
        errors++;
        $display("FAIL rr_grant_%0d got no ack in 20 cycles exp %s", k, (k % 2 == 0) ? "store" : "load");
      end else if ({st_ack, ld_ack} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL rr_grant_%0d got st_ack=%b ld_ack=%b exp %s", k, st_ack, ld_ack,
                 (k % 2 == 0) ? "store" : "load");
      end
    end
    st_req = 1'b0;
    ld_req = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      tick();
      if (!busy) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL rr_drain got busy=%b exp 0 within 20 cycles", busy);
    end
  endtask

  task automatic test_same_addr();
    logic found;
    st_req = 1'b1; st_addr = 16'h0030; st_data = 16'h1111;
    tick();
    st_req = 1'b0;
    tick();
    st_req = 1'b1; st_addr = 16'h0030; st_data = 16'hC0DE;
    ld_req = 1'b1; ld_addr = 16'h0030; ld_tag = 4'd7;
    tick();
    checks++;
    if ({st_ack, ld_ack, mem_wdata} !== {2'b10, 16'hC0DE}) begin
      errors++;
      $display("FAIL same_addr_store_first got sa=%b la=%b wd=%h exp 1 0 c0de", st_ack, ld_ack, mem_wdata);
    end
    st_req = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      tick();
      if (ld_ack) found = 1'b1;
    end
    ld_req = 1'b0;
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL same_addr_load_ack got none exp ld_ack within 10 cycles");
    end
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      tick();
      if (cdb_valid) found = 1'b1;
    end
    checks++;
    if (!found || {cdb_tag, cdb_data} !== {4'd7, 16'hC0DE}) begin
      errors++;
      $display("FAIL same_addr_forward got v=%b tag=%h data=%h exp 1 7 c0de", found, cdb_tag, cdb_data);
    end
    tick();
    tick();
  endtask

  task automatic test_stall();
    logic found;
    int   n;
    ld_req = 1'b1; ld_addr = 16'h0060; ld_tag = 4'd9;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      tick();
      if (ld_ack) found = 1'b1;
    end
    ld_req = 1'b0;
    cdb_stall = 1'b1;
    st_req = 1'b1; st_addr = 16'h0070; st_data = 16'h7777;
    for (int c = 0; c < 10 && !cdb_valid; c++) tick();
    n = 0;
    while (cdb_valid && n < 10) begin
      n++;
      checks++;
      if ({cdb_tag, cdb_data, st_ack} !== {4'd9, 16'hA060, 1'b0}) begin
        errors++;
        $display("FAIL stall_hold_%0d got tag=%h data=%h st_ack=%b exp 9 a060 0", n, cdb_tag, cdb_data, st_ack);
      end
      if (n >= 4) cdb_stall = 1'b0;
      tick();
    end
    cdb_stall = 1'b0;
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL stall_length got %0d cycles of cdb_valid exp 4", n);
    end
    checks++;
    if ({st_ack, busy} !== 2'b00) begin
      errors++;
      $display("FAIL stall_idle got st_ack=%b busy=%b exp 00", st_ack, busy);
    end
    tick();
    checks++;
    if ({st_ack, mem_addr, mem_wdata} !== {1'b1, 16'h0070, 16'h7777}) begin
      errors++;
      $display("FAIL stall_pending_store got ack=%b addr=%h wd=%h exp 1 0070 7777", st_ack, mem_addr, mem_wdata);
    end
    st_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    int seen;
    ld_req = 1'b1; ld_addr = 16'h0020; ld_tag = 4'd3;
    tick();
    ld_req = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if ({st_ack, ld_ack, mem_en, mem_we, cdb_valid, busy, mem_addr, mem_wdata, cdb_tag, cdb_data} !== '0) begin
      errors++;
      $display("FAIL reset_async got en=%b v=%b busy=%b addr=%h tag=%h data=%h exp all zero",
               mem_en, cdb_valid, busy, mem_addr, cdb_tag, cdb_data);
    end
    tick();
    reset = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (cdb_valid || ld_ack) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL reset_no_bcast got %0d cycles with ack/cdb_valid exp 0", seen);
    end
    ld_req = 1'b1; ld_addr = 16'h0021; ld_tag = 4'd5;
    tick();
    checks++;
    if ({ld_ack, mem_en, mem_addr} !== {2'b11, 16'h0021}) begin
      errors++;
      $display("FAIL reset_reload_ack got la=%b en=%b addr=%h exp 1 1 0021", ld_ack, mem_en, mem_addr);
    end
    ld_req = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if ({cdb_valid, cdb_tag, cdb_data} !== {1'b1, 4'd5, 16'hA021}) begin
      errors++;
      $display("FAIL reset_reload_bcast got v=%b tag=%h data=%h exp 1 5 a021", cdb_valid, cdb_tag, cdb_data);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_round_robin();
    test_same_addr();
    test_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got simulation still running exp finish before 200000 time units");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
